// File: rtl/reg_list_sequencer.sv
// LDM/STM register-list sequencer: walks reg_list lowest-first, handshakes one memory beat per register.
// Optional base-register writeback state enabled by defining REG_SEQ_WRITEBACK_EN.
module reg_list_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_load,
    input  logic          up,
    input  logic [15:0]   reg_list,
    input  logic [AW-1:0] base_addr,
    input  logic [3:0]    base_reg,
    input  logic [DW-1:0] rf_pa,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [3:0]    rf_a,
    output logic [3:0]    rf_c,
    output logic [DW-1:0] rf_pc,
    output logic          rf_ld,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] wb_addr
);

`ifdef REG_SEQ_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SCAN, XFER, WB, DONE} state_t;

    state_t        state, state_n;
    logic [15:0]   list_q;
    logic [3:0]    idx_q;
    logic [3:0]    base_reg_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] wb_q;
    logic          load_q;
    logic          wb_skip_q;

    logic [4:0]    cnt;
    logic [AW-1:0] span;
    logic [3:0]    low_idx;
    logic          found;

    // popcount of the incoming list and lowest remaining set bit of the working list
    always_comb begin
        cnt     = '0;
        low_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (reg_list[i]) cnt = cnt + 5'd1;
            if (list_q[i] && !found) begin
                low_idx = 4'(i);
                found   = 1'b1;
            end
        end
        span = AW'({cnt, 2'b00});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            list_q     <= '0;
            idx_q      <= '0;
            base_reg_q <= '0;
            addr_q     <= '0;
            wb_q       <= '0;
            load_q     <= 1'b0;
            wb_skip_q  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    list_q     <= reg_list;
                    load_q     <= is_load;
                    base_reg_q <= base_reg;
                    wb_skip_q  <= is_load & reg_list[base_reg];
                    addr_q     <= up ? base_addr : base_addr - span;
                    wb_q       <= up ? base_addr + span : base_addr - span;
                end
                SCAN: if (found) begin
                    idx_q           <= low_idx;
                    list_q[low_idx] <= 1'b0;
                end
                XFER: if (mem_ready) addr_q <= addr_q + AW'(4);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = SCAN;
            SCAN: begin
                if (found)                  state_n = XFER;
                else if (WB_EN && !wb_skip_q) state_n = WB;
                else                        state_n = DONE;
            end
            XFER: if (mem_ready) state_n = SCAN;
            WB:   state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // outputs decode straight from state so a reset drops them without waiting for a clock
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        mem_req   = (state == XFER);
        mem_we    = (state == XFER) && !load_q;
        mem_addr  = addr_q;
        mem_wdata = ((state == XFER) && !load_q) ? rf_pa : '0;
        wb_addr   = wb_q;
        rf_a      = idx_q;
        rf_c      = idx_q;
        rf_pc     = '0;
        rf_ld     = 1'b0;
        if ((state == XFER) && load_q && mem_ready) begin
            rf_pc = mem_rdata;
            rf_ld = 1'b1;
        end else if (state == WB) begin
            rf_c  = base_reg_q;
            rf_pc = DW'(wb_q);
            rf_ld = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Randomized bench for reg_list_sequencer against a list/queue-based transfer model.
// Writeback expectations follow REG_SEQ_WRITEBACK_EN when it is defined for the build.
module tb_reg_list_sequencer;

`ifdef REG_SEQ_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        up = 1'b0;
    logic [15:0] reg_list = '0;
    logic [31:0] base_addr = '0;
    logic [3:0]  base_reg = '0;
    logic [31:0] rf_pa;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b0;
    logic [3:0]  rf_a, rf_c;
    logic [31:0] rf_pc;
    logic        rf_ld, mem_req, mem_we, busy, done;
    logic [31:0] mem_addr, mem_wdata, wb_addr;

    logic [31:0] rf      [16];
    logic [31:0] init_rf [16];
    logic [31:0] exp_rf  [16];
    logic        load_rf = 1'b1;
    logic [31:0] salt = 32'h0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    reg_list_sequencer #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .up(up),
        .reg_list(reg_list), .base_addr(base_addr), .base_reg(base_reg),
        .rf_pa(rf_pa), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rf_a(rf_a), .rf_c(rf_c), .rf_pc(rf_pc), .rf_ld(rf_ld),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .wb_addr(wb_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    assign rf_pa     = rf[rf_a];
    assign mem_rdata = mem_val(mem_addr, salt);

    always @(posedge clk) begin
        if (load_rf) begin
            for (int i = 0; i < 16; i++) rf[i] <= init_rf[i];
        end else if (rf_ld) begin
            rf[rf_c] <= rf_pc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input bit ld, input bit u, input logic [15:0] lst,
                           input logic [31:0] base, input logic [3:0] br,
                           input int ready_pct, input int abort_beat);
        int          n;
        int          cyc;
        int          beats;
        bit          fin;
        bit          wb_exp;
        bit          wb_seen;
        logic [31:0] first, wb;
        int          q_reg[$];
        logic [31:0] q_addr[$];
        n      = $countones(lst);
        first  = u ? base : base - 32'(4 * n);
        wb     = u ? base + 32'(4 * n) : base - 32'(4 * n);
        wb_exp = WB_EN && ld && !lst[br];
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                q_addr.push_back(first + 32'(4 * q_reg.size()));
                q_reg.push_back(i);
            end
        end
        salt = $urandom;

        @(negedge clk);
        start = 1'b1; is_load = ld; up = u; reg_list = lst; base_addr = base; base_reg = br;
        mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; is_load = $urandom; up = $urandom; reg_list = 16'($urandom);
        base_addr = $urandom; base_reg = 4'($urandom);
        cyc = 1; beats = 0; fin = 1'b0; wb_seen = 1'b0;
        while (!fin && cyc < 400) begin
            start     = (cyc == 3);
            mem_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (abort_beat >= 0 && beats == abort_beat && mem_req) begin
                rst_n = 1'b0;
                #1;
                check("abort_mem_req", mem_req, 0);
                check("abort_rf_ld", rf_ld, 0);
                check("abort_busy", busy, 0);
                check("abort_mem_addr", mem_addr, 0);
                @(negedge clk);
                rst_n = 1'b1; start = 1'b0; mem_ready = 1'b0;
                return;
            end
            if (mem_req) begin
                if (q_addr.size() == 0) begin
                    check("extra_mem_req", 1, 0);
                end else begin
                    check("mem_addr", mem_addr, q_addr[0]);
                    check("mem_we", mem_we, !ld);
                    if (mem_ready) begin
                        if (ld) begin
                            check("ldm_rf_ld", rf_ld, 1);
                            check("ldm_rf_c", rf_c, q_reg[0]);
                            check("ldm_rf_pc", rf_pc, mem_val(q_addr[0], salt));
                            exp_rf[q_reg[0]] = mem_val(q_addr[0], salt);
                        end else begin
                            check("stm_rf_ld", rf_ld, 0);
                            check("stm_wdata", mem_wdata, exp_rf[q_reg[0]]);
                        end
                        void'(q_addr.pop_front());
                        void'(q_reg.pop_front());
                        beats++;
                    end else begin
                        check("stall_rf_ld", rf_ld, 0);
                    end
                end
            end else if (rf_ld) begin
                check("wb_allowed", wb_exp && !wb_seen, 1);
                check("wb_rf_c", rf_c, br);
                check("wb_rf_pc", rf_pc, wb);
                wb_seen = 1'b1;
            end
            if (done) begin
                check("beats_left", q_addr.size(), 0);
                check("wb_addr", wb_addr, wb);
                check("wb_written", wb_seen, wb_exp);
                if (ready_pct == 100) check("latency", cyc, 2 * n + 2 + int'(wb_exp));
                fin = 1'b1;
                start = 1'b1;
                reg_list = 16'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) check("done_timeout", 0, 1);
        start = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_mem_req", mem_req, 0);
        if (wb_exp) exp_rf[br] = wb;
        for (int i = 0; i < 16; i++) check($sformatf("rf_R%0d", i), rf[i], exp_rf[i]);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            init_rf[i] = $urandom;
            exp_rf[i]  = init_rf[i];
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_rf_ld", rf_ld, 0);
        check("rst_rf_a", rf_a, 0);
        check("rst_rf_c", rf_c, 0);
        check("rst_rf_pc", rf_pc, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_wb_addr", wb_addr, 0);
        load_rf = 1'b0;
        rst_n   = 1'b1;

        run_txn(1'b0, 1'b1, 16'h0016, 32'h100, 4'd0, 100, -1);
        run_txn(1'b1, 1'b0, 16'h8001, 32'h200, 4'd0, 100, -1);
        run_txn(1'b0, 1'b1, 16'h0F0F, 32'h300, 4'd0, 30, -1);
        run_txn(1'b1, 1'b1, 16'h00F0, 32'h340, 4'd1, 40, -1);
        run_txn(1'b0, 1'b1, 16'h0000, 32'h500, 4'd2, 100, -1);
        run_txn(1'b0, 1'b1, 16'h0F00, 32'h400, 4'd0, 100, 1);
        run_txn(1'b1, 1'b1, 16'h0006, 32'h600, 4'd3, 100, -1);
        run_txn(1'b1, 1'b1, 16'h0008, 32'h700, 4'd3, 100, -1);
        run_txn(1'b1, 1'b0, 16'h00FF, 32'h0000_0010, 4'd9, 100, -1);
        run_txn(1'b0, 1'b1, 16'hC003, 32'hFFFF_FFF8, 4'd5, 100, -1);
        for (int t = 0; t < 20; t++) begin
            logic [31:0] b;
            b = $urandom;
            b[1:0] = 2'b00;
            run_txn(1'($urandom), 1'($urandom), 16'($urandom), b, 4'($urandom),
                    (t % 2 == 0) ? 100 : 50, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
